// File: rtl/pred_issue.sv
// Predicate-evaluation sequencer: 1-entry hold, stalls on pending predicate writes, accept->out_valid 2 cycles;
// valid/ready both sides, one instr per 2 cycles. Scoreboard built only with `PRED_SCOREBOARD_EN defined.
module pred_issue #(
  parameter int unsigned CNT_W     = 2,
  parameter logic [31:0] NOP       = 32'h0000_0013,
  parameter logic [15:0] PRIV_REGS = 16'hC000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [3:0]  reg_addr,
  input  logic [31:0] reg_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [26:0] out_instr,
  output logic        out_squashed,
  output logic        out_priv,
  input  logic        alloc_valid,
  input  logic [3:0]  alloc_addr,
  output logic        alloc_ready,
  input  logic        wb_valid,
  input  logic [3:0]  wb_addr,
  input  logic        flush
);

  typedef enum logic [1:0] {EMPTY, EVAL, VALID} state_t;

  state_t      state_q, state_d;
  logic [31:0] hold_q, hold_d;
  logic [26:0] out_instr_q, out_instr_d;
  logic        out_squashed_q, out_squashed_d;
  logic        out_priv_q, out_priv_d;
  logic        out_valid_q, out_valid_d;
  logic        stall, pred, accept;

  function automatic logic privileged(input logic [3:0] addr);
    return PRIV_REGS[addr];
  endfunction

  assign reg_addr     = hold_q[31:28];
  assign in_ready     = !flush && (state_q == EMPTY || (state_q == VALID && out_ready));
  assign accept       = in_valid && in_ready;
  assign pred         = (reg_value == 32'd0) ^ hold_q[27];
  assign out_valid    = out_valid_q;
  assign out_instr    = out_instr_q;
  assign out_squashed = out_squashed_q;
  assign out_priv     = out_priv_q;

`ifdef PRED_SCOREBOARD_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [16];
  logic [CNT_W-1:0] cnt_d [16];

  assign alloc_ready = (alloc_addr == 4'd0) || (cnt_q[alloc_addr] != CNT_MAX);
  // Registered count: a release seen this cycle only unblocks EVAL next cycle.
  assign stall       = (cnt_q[hold_q[31:28]] != '0);

  always_comb begin
    for (int r = 0; r < 16; r++) begin
      logic inc, dec;
      inc = alloc_valid && alloc_ready && (alloc_addr == 4'(r));
      dec = wb_valid && (wb_addr == 4'(r));
      cnt_d[r] = cnt_q[r];
      if (r == 0)
        cnt_d[r] = '0;
      else if (inc && !dec)
        cnt_d[r] = cnt_q[r] + 1'b1;
      else if (dec && !inc && cnt_q[r] != '0)
        cnt_d[r] = cnt_q[r] - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 16; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < 16; r++) cnt_q[r] <= cnt_d[r];
    end
  end
`else
  localparam int unsigned unused_cnt_w = CNT_W;
  logic unused_sb;

  assign alloc_ready = 1'b1;
  assign stall       = 1'b0;
  assign unused_sb   = ^{alloc_valid, alloc_addr, wb_valid, wb_addr};
`endif

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    out_instr_d    = out_instr_q;
    out_squashed_d = out_squashed_q;
    out_priv_d     = out_priv_q;
    out_valid_d    = out_valid_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          hold_d  = in_instr;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (!stall) begin
          out_instr_d    = pred ? hold_q[26:0] : NOP[26:0];
          out_squashed_d = !pred;
          out_priv_d     = privileged(reg_addr);
          out_valid_d    = 1'b1;
          state_d        = VALID;
        end
      end
      VALID: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (accept) begin
            hold_d  = in_instr;
            state_d = EVAL;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush wins; an output handshake in the same cycle has already happened.
    if (flush) begin
      state_d     = EMPTY;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= EMPTY;
      hold_q         <= '0;
      out_instr_q    <= '0;
      out_squashed_q <= 1'b0;
      out_priv_q     <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_q         <= hold_d;
      out_instr_q    <= out_instr_d;
      out_squashed_q <= out_squashed_d;
      out_priv_q     <= out_priv_d;
      out_valid_q    <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_pred_issue.sv
// Bench for pred_issue: directed timing/boundary checks plus a randomized scoreboard run.
module tb_pred_issue;

  localparam int          CNT_W     = 2;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [15:0] PRIV_REGS = 16'hC000;
  localparam int          MAXC      = (1 << CNT_W) - 1;
`ifdef PRED_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b0, alloc_valid = 1'b0, wb_valid = 1'b0, flush = 1'b0;
  logic [31:0] in_instr = '0;
  logic [3:0]  alloc_addr = '0, wb_addr = '0;
  logic        in_ready, out_valid, out_squashed, out_priv, alloc_ready;
  logic [3:0]  reg_addr;
  logic [31:0] reg_value;
  logic [26:0] out_instr;

  logic [31:0] rf [16];
  int          mcnt [16];
  int          errors = 0;
  int          checks = 0;
  bit          sb_en = 1'b0;
  bit          held = 1'b0;
  logic [28:0] held_out;
  logic [28:0] exp_q [$];

  assign reg_value = rf[reg_addr];

  pred_issue #(.CNT_W(CNT_W), .NOP(NOP_INSTR), .PRIV_REGS(PRIV_REGS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .reg_addr(reg_addr), .reg_value(reg_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_squashed(out_squashed), .out_priv(out_priv),
    .alloc_valid(alloc_valid), .alloc_addr(alloc_addr), .alloc_ready(alloc_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected {priv, squashed, instr} from the predicate rule applied to the bench register file.
  function automatic logic [28:0] expect_of(input logic [31:0] ins);
    logic [31:0] nop_v;
    logic [3:0]  r;
    logic        p;
    nop_v = NOP_INSTR;
    r     = ins[31:28];
    p     = (rf[r] == 32'd0) ^ ins[27];
    return {PRIV_REGS[r], !p, p ? ins[26:0] : nop_v[26:0]};
  endfunction

  function automatic logic exp_ready(input logic [3:0] a);
    return !SB || a == 4'd0 || mcnt[a] < MAXC;
  endfunction

  task automatic model_update();
    bit a, w;
    if (rst) begin
      foreach (mcnt[i]) mcnt[i] = 0;
      return;
    end
    a = alloc_valid && exp_ready(alloc_addr) && alloc_addr != 4'd0;
    w = wb_valid && wb_addr != 4'd0;
    if (a && w && alloc_addr == wb_addr) return;
    if (a) mcnt[alloc_addr]++;
    if (w && mcnt[wb_addr] > 0) mcnt[wb_addr]--;
  endtask

  // One clock with the currently driven inputs; returns at posedge+1.
  task automatic step();
    #1;
    chk("alloc_ready", alloc_ready, exp_ready(alloc_addr));
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string nm, input logic [31:0] ins, input logic [26:0] ei,
                         input logic esq, input logic epriv);
    in_valid = 1'b1; in_instr = ins; out_ready = 1'b1;
    #1 chk({nm, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    chk({nm, "_lat1"}, out_valid, 0);
    step();
    chk({nm, "_lat2"}, out_valid, 1);
    chk({nm, "_instr"}, out_instr, ei);
    chk({nm, "_sq"}, out_squashed, esq);
    chk({nm, "_priv"}, out_priv, epriv);
    step();
    chk({nm, "_taken"}, out_valid, 0);
  endtask

  // Scoreboard monitor: pushes on accepted input, pops on output handshake.
  always @(negedge clk) begin
    if (sb_en && !rst) begin
      if (held) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", {out_priv, out_squashed, out_instr}, held_out);
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_unexpected: got %h expected nothing", {out_priv, out_squashed, out_instr});
        end else begin
          chk("sb_out", {out_priv, out_squashed, out_instr}, exp_q.pop_front());
        end
      end else if (out_valid) begin
        held = 1'b1;
        held_out = {out_priv, out_squashed, out_instr};
      end
      if (in_valid && in_ready) exp_q.push_back(expect_of(in_instr));
    end
  end

  initial begin
    int n;
    foreach (rf[i]) rf[i] = '0;
    foreach (mcnt[i]) mcnt[i] = 0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_sq", out_squashed, 0);
    chk("rst_out_priv", out_priv, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rst_in_ready", in_ready, 1);

    // Predicate evaluation and latency
    run_one("true", 32'h3000_1234, 27'h0001234, 1'b0, 1'b0);
    rf[3] = 32'd5;
    run_one("false", 32'h3000_1234, NOP_INSTR[26:0], 1'b1, 1'b0);
    run_one("invert", 32'h3800_1234, 27'h0001234, 1'b0, 1'b0);
    rf[15] = 32'd0;
    run_one("priv", 32'hF7AB_CDEF, 27'h7ABCDEF, 1'b0, 1'b1);

    // Stall on two outstanding writes to the predicate register
    rf[3] = 32'd0;
    alloc_valid = 1'b1; alloc_addr = 4'd3;
    step(); step();
    alloc_valid = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h3000_1234;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    chk("stall_2pend", out_valid, !SB);
    wb_valid = 1'b1; wb_addr = 4'd3;
    step();
    wb_valid = 1'b0;
    step();
    chk("stall_1pend", out_valid, !SB);
    wb_valid = 1'b1;
    step();
    wb_valid = 1'b0;
    chk("release_n1", out_valid, !SB);
    step();
    chk("release_n2", out_valid, 1);
    chk("release_instr", out_instr, 27'h0001234);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // Counter saturation, simultaneous alloc+wb, wb at zero
    alloc_valid = 1'b1; alloc_addr = 4'd0;
    #1 chk("alloc_rdy_r0", alloc_ready, 1);
    alloc_addr = 4'd5;
    step(); step(); step();
    chk("sat_after3", alloc_ready, !SB);
    step();
    alloc_valid = 1'b0; wb_valid = 1'b1; wb_addr = 4'd5;
    step();
    alloc_valid = 1'b1;
    step();
    wb_valid = 1'b0;
    chk("same_cycle_rdy", alloc_ready, 1);
    step();
    chk("same_cycle_sat", alloc_ready, !SB);
    alloc_valid = 1'b0; wb_valid = 1'b1;
    step(); step(); step();
    wb_addr = 4'd7;
    step();
    wb_valid = 1'b0; alloc_addr = 4'd7;
    #1 chk("wb_zero_rdy", alloc_ready, 1);
    alloc_valid = 1'b1;
    step(); step();
    chk("wb_zero_2", alloc_ready, 1);
    step();
    chk("wb_zero_3", alloc_ready, !SB);
    alloc_valid = 1'b0; wb_valid = 1'b1;
    step(); step(); step();
    wb_valid = 1'b0;

    // Backpressure then back-to-back accept on the output handshake
    rf[3] = 32'd0;
    in_valid = 1'b1; in_instr = 32'h3000_1234; out_ready = 1'b0;
    step();
    in_instr = 32'h3800_5678;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_instr", out_instr, 27'h0001234);
      chk("bp_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    #1 chk("b2b_in_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("b2b_eval", out_valid, 0);
    step();
    chk("b2b_valid", out_valid, 1);
    chk("b2b_instr", out_instr, NOP_INSTR[26:0]);
    chk("b2b_sq", out_squashed, 1);
    step();

    // Flush in EVAL and in VALID
    in_valid = 1'b1; in_instr = 32'h3000_1234; out_ready = 1'b0;
    step();
    in_valid = 1'b0; flush = 1'b1;
    #1 chk("flush_in_ready", in_ready, 0);
    step();
    flush = 1'b0;
    chk("flush_eval_1", out_valid, 0);
    step();
    chk("flush_eval_2", out_valid, 0);
    chk("flush_eval_empty", in_ready, 1);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk("pre_flush_valid", out_valid, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_valid_1", out_valid, 0);
    step();
    chk("flush_valid_2", out_valid, 0);

    // Asynchronous reset in the middle of a stall
    alloc_valid = 1'b1; alloc_addr = 4'd15;
    step(); step(); step();
    alloc_valid = 1'b0;
    in_valid = 1'b1; in_instr = 32'hF000_00AA;
    step();
    in_valid = 1'b0;
    step(); step();
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_instr", out_instr, 0);
    chk("arst_sq", out_squashed, 0);
    chk("arst_priv", out_priv, 0);
    chk("arst_cnt", alloc_ready, 1);
    model_update();
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("arst_in_ready", in_ready, 1);

    // Randomized run against the scoreboard
    foreach (rf[i]) rf[i] = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
    exp_q.delete();
    held = 1'b0;
    sb_en = 1'b1;
    for (int c = 0; c < 800; c++) begin
      in_valid    = $urandom_range(0, 1);
      in_instr    = $urandom;
      out_ready   = ($urandom_range(0, 3) != 0);
      alloc_valid = ($urandom_range(0, 3) == 0);
      alloc_addr  = 4'($urandom_range(0, 15));
      wb_valid    = $urandom_range(0, 1);
      wb_addr     = 4'($urandom_range(0, 15));
      step();
    end
    in_valid = 1'b0; alloc_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      wb_addr = 4'(n % 16);
      step();
      n++;
    end
    wb_valid = 1'b0;
    step();
    sb_en = 1'b0;
    chk("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pred_issue.md
# pred_issue

Decode-stage sequencer that owns the predicate-evaluation step: it buffers one fetched instruction, holds it while its predicate register has an outstanding write, reads the register, and hands the predicated 27-bit instruction (or NOP) downstream over valid/ready. It also keeps a per-register pending-write scoreboard fed by allocation at issue and release at writeback. It sits between fetch and the rest of decode and drives one register-file read port.

## Interface

- `CNT_W`, default 2: width of each per-register pending-write counter (max outstanding writes = 2^CNT_W-1).
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: fetch offers `in_instr`.
- `in_ready` out 1: block accepts `in_instr` this cycle.
- `in_instr` in 32: raw instruction; [31:28] predicate register, [27] predicate invert.
- `reg_addr` out 4: register-file read address; combinational read, same-cycle `reg_value`.
- `reg_value` in 32: register-file read data.
- `out_valid` out 1: `out_instr`/`out_priv` valid.
- `out_ready` in 1: downstream takes the output.
- `out_instr` out 27: instr[26:0] if predicate true, else `NOP`[26:0] (from asm.vh).
- `out_squashed` out 1: 1 when `out_instr` is the substituted NOP.
- `out_priv` out 1: privileged flag of the predicate register (existing `privileged` decode on `reg_addr`), registered with the output.
- `alloc_valid` in 1: downstream issued an instruction that writes `alloc_addr`.
- `alloc_addr` in 4: destination register of the allocation.
- `alloc_ready` out 1: counter for `alloc_addr` is below max; an allocation is accepted only when `alloc_valid && alloc_ready`.
- `wb_valid` in 1: writeback of `wb_addr` completed this cycle.
- `wb_addr` in 4: register written back.
- `flush` in 1: discard the held instruction.

## Operation

- States: EMPTY, EVAL, VALID.
- EMPTY: `in_ready`=1; on `in_valid`, latch `in_instr` into the hold register -> EVAL.
- EVAL: `reg_addr`=hold[31:28]. If pending[hold[31:28]]!=0, stay in EVAL (stall). Otherwise pred = (`reg_value`==0) XOR hold[27]; register `out_instr` (hold[26:0] if pred, else `NOP`[26:0]), `out_squashed`=!pred, `out_priv` -> VALID.
- VALID: `out_valid`=1, outputs stable until taken. On `out_ready`: if `in_valid`, latch new instruction -> EVAL; else -> EMPTY.
- `in_ready` = !flush && (state==EMPTY || (state==VALID && out_ready)).
- In EMPTY/VALID, `reg_addr` = hold[31:28] (don't-care for the register file).
- Scoreboard: counters for registers 1..15; register 0 is never pending, and alloc/wb to 0 are ignored.
  - An accepted alloc increments its counter; wb decrements it.
  - Accepted alloc and wb to the same register in the same cycle leave the counter unchanged.
  - wb on a zero counter is ignored (no underflow).
  - `alloc_ready` is 0 when the counter is at 2^CNT_W-1, and 1 for address 0.
- Stall check uses the registered counter value. A register released by wb in cycle N is evaluable from cycle N+1, which guarantees the register file has been written.
- `flush`: next state EMPTY regardless of current state; `out_valid` drops the next cycle. A handshake completing in the flush cycle still counts. The scoreboard is unaffected.

## Timing

- Reset (asynchronous): state EMPTY, `out_valid`=0, `out_instr`=0, `out_squashed`=0, `out_priv`=0, hold=0, all counters 0. `in_ready`=1 after reset release.
- Latency: input accepted in cycle N with no pending write -> `out_valid` in N+2.
- Each stall cycle adds 1 cycle of latency.
- Throughput: one instruction per 2 cycles; back-to-back accept is only on an output handshake.
- `alloc_ready` is combinational from `alloc_addr` and the counters. All other outputs are registered, except `in_ready` and `reg_addr`.

## Configuration

- `PRED_SCOREBOARD_EN` defined: scoreboard as above.
- Not defined:
  - no counters are built;
  - `alloc_ready` is tied to 1;
  - `alloc_*`/`wb_*` are ignored;
  - EVAL never stalls (VALID always follows EVAL by one cycle).

## Test plan

- Instr 0x3000_1234 (reg 3, no invert), reg 3=0, out_ready=1 -> `out_valid` 2 cycles after accept, `out_instr`=0x0001234, `out_squashed`=0.
- Same instr with reg 3=5 -> `out_instr`=`NOP`[26:0], `out_squashed`=1. Instr 0x3800_1234 (invert) with reg 3=5 -> `out_instr`=0x0001234.
- Alloc reg 3 twice, present instr on reg 3 -> holds in EVAL. After one wb, still stalled; after the second wb in cycle N -> `out_valid` at N+2. Without `PRED_SCOREBOARD_EN` -> no stall.
- Four allocs to reg 5 with CNT_W=2 -> `alloc_ready`=0 after the third. Simultaneous alloc+wb to reg 5 -> count unchanged. wb to reg 7 at 0 -> stays 0.
- `out_ready`=0 for 5 cycles -> outputs stable, `in_ready`=0. Then `out_ready`=1 with `in_valid`=1 -> new instruction accepted the same cycle.
- `flush` asserted in EVAL and in VALID -> EMPTY next cycle, `out_valid`=0. Assert `rst` mid-stall -> all outputs and counters 0 immediately.
